load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory request at a time and performs loads,
// word stores and read-modify-write sub-word stores against a 64x32 memory.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [5:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE_W,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] old_q, old_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_bad;
    logic        accept;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= '0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            old_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            old_q    <= old_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        req_bad = (req_size == 2'b11)
               || (req_size == SZ_HALF && req_addr[0])
               || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
    end

    // Lane extraction from the live memory word, selected by the latched request.
    always_comb begin
        lane_byte = '0;
        lane_half = '0;
        load_val  = mem_rdata;
        case (addr_q[1:0])
            2'd0:    lane_byte = mem_rdata[7:0];
            2'd1:    lane_byte = mem_rdata[15:8];
            2'd2:    lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
        lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_val = signed_q ? {{24{lane_byte[7]}}, lane_byte}
                                         : {24'd0, lane_byte};
            SZ_HALF: load_val = signed_q ? {{16{lane_half[15]}}, lane_half}
                                         : {16'd0, lane_half};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        merged = old_q;
        if (size_q == SZ_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        old_d    = old_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        accept   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept   = 1'b1;
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = req_bad;
                    if (req_bad)
                        state_d = S_RESP;
                    else if (!req_we)
                        state_d = S_LOAD;
                    else if (req_size == SZ_WORD)
                        state_d = S_STORE_W;
                    else
                        state_d = S_RMW_RD;
                end
            end
            S_LOAD: begin
                if (!we_q)
                    rdata_d = load_val;
                state_d = S_RESP;
            end
            S_STORE_W: state_d = S_RESP;
            S_RMW_RD: begin
                old_d   = mem_rdata;
                state_d = S_RMW_WR;
            end
            S_RMW_WR: state_d = S_RESP;
            S_RESP: begin
                // Response fields are cleared on handoff so IDLE presents zeros.
                if (resp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_LOAD: begin
                mem_read_enable = 1'b1;
                mem_addr        = addr_q[7:2];
            end
            S_STORE_W: begin
                mem_write_enable = 1'b1;
                mem_addr         = addr_q[7:2];
                mem_wdata        = wdata_q;
            end
            S_RMW_RD: begin
                mem_read_enable = 1'b1;
                mem_addr        = addr_q[7:2];
            end
            S_RMW_WR: begin
                mem_write_enable = 1'b1;
                mem_addr         = addr_q[7:2];
                mem_wdata        = merged;
            end
            S_RESP: resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
